sd_sector_buffer: RTL and testbench
===================================

// Module: sd_sector_buffer
// PURPOSE
// - 512-byte sector buffer directly downstream of the SD-card sector reader; captures its byte-write strobes (data/addr/wr) into on-chip RAM.
// - Requests sectors from the reader (start pulse) and, once a sector is complete, streams it to a consumer (file-system/VGA loader) over valid/ready.
// - Single buffer: strictly fill -> drain -> refill; no overlap.
// PARAMETERS
// - DEPTH  512  bytes per sector (buffer size)
// - AW     9    index width, clog2(DEPTH)
// PORTS
// - i_clk          in   1   system clock
// - i_rst_n        in   1   reset, synchronous, active-low
// - i_fetch        in   1   consumer request for next sector (level, sampled in EMPTY)
// - o_start_read   out  1   one-cycle pulse to reader's start-read input
// - i_wr_nrd       in   1   reader byte-write strobe (1 cycle per byte)
// - i_wr_addr      in   32  reader byte index
// - i_wr_data      in   8   reader byte
// - i_read_done    in   1   reader sector-complete pulse
// - o_rd_valid     out  1   stream byte valid
// - o_rd_data      out  8   stream byte
// - o_rd_index     out  AW  index of o_rd_data within sector
// - i_rd_ready     in   1   consumer accepts byte when valid&&ready
// - o_drained      out  1   one-cycle pulse after last byte accepted
// - o_busy         out  1   high in any state except EMPTY
// - o_overflow     out  1   sticky: a write was dropped
// - o_checksum     out  8   sector checksum (see CONFIGURATION)
// BEHAVIOUR
// - Reset (i_rst_n=0 at clk edge): state EMPTY; all outputs 0; pointers 0; RAM contents not cleared. Reset mid-fill/drain aborts with no pulses.
// - States: EMPTY -> REQ -> FILLING -> FULL -> FETCH -> PRESENT -> (FETCH | EMPTY).
// - EMPTY: if i_fetch, next state REQ. REQ: o_start_read=1 for exactly this cycle; -> FILLING.
// - FILLING: on i_wr_nrd with i_wr_addr<DEPTH write RAM[i_wr_addr[AW-1:0]]<=i_wr_data; i_wr_addr>=DEPTH write dropped, o_overflow<=1 (reader emits index 512; must be dropped, not wrapped).
//   i_read_done -> FULL; write and done same cycle: write performed, then FULL.
// - i_wr_nrd outside FILLING: dropped, o_overflow<=1. i_read_done outside FILLING: ignored. i_fetch outside EMPTY: ignored.
// - FULL: rd pointer<=0; -> FETCH.
// - FETCH: synchronous RAM read of RAM[ptr]; -> PRESENT next cycle with o_rd_data/o_rd_index registered.
// - PRESENT: o_rd_valid=1, data/index held stable until accepted. On valid&&ready: valid drops next cycle;
//   if ptr==DEPTH-1 -> EMPTY with o_drained=1 for one cycle, else ptr<=ptr+1, -> FETCH.
// - Throughput 1 byte / 2 cycles with ready held high; first valid 2 cycles after i_read_done sampled.
// - o_busy=(state!=EMPTY). o_overflow cleared only by reset.
// - Pointer arithmetic AW bits; ptr never wraps (terminates at DEPTH-1).
// CONFIGURATION
// - Macro SD_SECTOR_BUF_CHECKSUM_EN.
// - Defined: 8-bit accumulator, zeroed in REQ, adds (mod 256) each byte written to RAM during FILLING; o_checksum valid from FULL until next REQ.
// - Undefined: no accumulator; o_checksum tied 8'h00.
// TESTING
// - Reset then i_fetch=1 -> o_start_read single pulse 1 cycle after fetch sampled; o_busy=1; pulse never repeats until drained.
// - Write bytes addr 0..511 data=addr[7:0], then addr 512 data 8'hAA, then i_read_done -> o_overflow=1; stream yields 512 bytes index 0..511 data=index[7:0], o_drained pulse after index 511.
// - Consumer ready toggled randomly -> o_rd_data/o_rd_index stable while valid&&!ready; no byte lost or duplicated.
// - Write strobe in same cycle as i_read_done (addr 511, data 8'h5C) -> byte 511 reads 8'h5C.
// - i_rst_n=0 for 1 cycle during FILLING at byte 100 -> state EMPTY, o_busy=0, no o_drained; next fetch restarts cleanly.
// - CHECKSUM_EN: all 512 bytes = 8'h01 -> o_checksum=8'h00; bytes 0..511 = index[7:0] -> o_checksum=8'h00; byte0=8'h7F rest 0 -> 8'h7F. Without macro -> 8'h00.

Source files
------------

// File: rtl/sd_sector_buffer.sv
// Single 512-byte sector buffer between the SD sector reader and a stream consumer.
// Optional sector checksum: define SD_SECTOR_BUF_CHECKSUM_EN.
module sd_sector_buffer #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_fetch,
    output logic          o_start_read,
    input  logic          i_wr_nrd,
    input  logic [31:0]   i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic          i_read_done,
    output logic          o_rd_valid,
    output logic [7:0]    o_rd_data,
    output logic [AW-1:0] o_rd_index,
    input  logic          i_rd_ready,
    output logic          o_drained,
    output logic          o_busy,
    output logic          o_overflow,
    output logic [7:0]    o_checksum
);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_REQ,
        S_FILLING,
        S_FULL,
        S_FETCH,
        S_PRESENT
    } state_t;

    localparam logic [31:0]   DEPTH_W = 32'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_nx;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] ptr;
    logic          addr_ok;
    logic          wr_en;
    logic          accept;
    logic          last_accept;

    // The reader emits one index past the sector end; it must be dropped, never wrapped.
    assign addr_ok     = (i_wr_addr < DEPTH_W);
    assign wr_en       = (state == S_FILLING) && i_wr_nrd && addr_ok;
    assign accept      = (state == S_PRESENT) && i_rd_ready;
    assign last_accept = accept && (ptr == LAST);
    assign o_busy      = (state != S_EMPTY);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nx     = state;
        o_start_read = 1'b0;
        o_rd_valid   = 1'b0;
        unique case (state)
            S_EMPTY: begin
                if (i_fetch) begin
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                o_start_read = 1'b1;
                state_nx     = S_FILLING;
            end
            S_FILLING: begin
                if (i_read_done) begin
                    state_nx = S_FULL;
                end
            end
            S_FULL: begin
                state_nx = S_FETCH;
            end
            S_FETCH: begin
                state_nx = S_PRESENT;
            end
            S_PRESENT: begin
                o_rd_valid = 1'b1;
                if (accept) begin
                    state_nx = (ptr == LAST) ? S_EMPTY : S_FETCH;
                end
            end
            default: begin
                state_nx = S_EMPTY;
            end
        endcase
    end

    // Sector RAM write port; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[i_wr_addr[AW-1:0]] <= i_wr_data;
        end
    end

    // Synchronous RAM read into the presented byte/index registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rd_data  <= 8'h00;
            o_rd_index <= '0;
        end else if (state == S_FETCH) begin
            o_rd_data  <= mem[ptr];
            o_rd_index <= ptr;
        end
    end

    // Read pointer: cleared on FULL, advanced per accepted byte, stops at the last byte.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else if (state == S_FULL) begin
            ptr <= '0;
        end else if (accept && !last_accept) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Drained pulse follows acceptance of the final byte.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_drained <= 1'b0;
        end else begin
            o_drained <= last_accept;
        end
    end

    // Sticky overflow: any write strobe that does not land in RAM.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_overflow <= 1'b0;
        end else if (i_wr_nrd && !wr_en) begin
            o_overflow <= 1'b1;
        end
    end

`ifdef SD_SECTOR_BUF_CHECKSUM_EN
    logic [7:0] csum;

    // Mod-256 sum of bytes stored this sector; restarts on each request.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            csum <= 8'h00;
        end else if (state == S_REQ) begin
            csum <= 8'h00;
        end else if (wr_en) begin
            csum <= csum + i_wr_data;
        end
    end

    assign o_checksum = csum;
`else
    assign o_checksum = 8'h00;
`endif

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Testbench for sd_sector_buffer: randomized fills/drains against an array model.
`timescale 1ns/1ps
module tb_sd_sector_buffer;

    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch = 1'b0;
    logic          wr = 1'b0;
    logic [31:0]   waddr = 32'h0;
    logic [7:0]    wdata = 8'h00;
    logic          done = 1'b0;
    logic          ready = 1'b0;
    logic          start_read;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic [AW-1:0] rd_index;
    logic          drained;
    logic          busy;
    logic          overflow;
    logic [7:0]    checksum;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    logic [7:0] ref_mem [DEPTH];
    int         got_data[$];
    int         got_idx[$];
    int         unstable;
    int         drain_cnt;
    bit         timed_out;

    sd_sector_buffer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_fetch      (fetch),
        .o_start_read (start_read),
        .i_wr_nrd     (wr),
        .i_wr_addr    (waddr),
        .i_wr_data    (wdata),
        .i_read_done  (done),
        .o_rd_valid   (rd_valid),
        .o_rd_data    (rd_data),
        .o_rd_index   (rd_index),
        .i_rd_ready   (ready),
        .o_drained    (drained),
        .o_busy       (busy),
        .o_overflow   (overflow),
        .o_checksum   (checksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_read) start_cnt++;
    end

    function automatic logic [7:0] exp_checksum();
`ifdef SD_SECTOR_BUF_CHECKSUM_EN
        int s = 0;
        for (int i = 0; i < DEPTH; i++) s += int'(ref_mem[i]);
        return 8'(s % 256);
`else
        return 8'h00;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fetch = 1'b0;
        wr = 1'b0;
        done = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_fetch(output bit s1, output bit b1, output bit s2);
        @(negedge clk);
        fetch = 1'b1;
        @(negedge clk);
        fetch = 1'b0;
        s1 = start_read;
        b1 = busy;
        @(negedge clk);
        s2 = start_read;
    endtask

    task automatic write_byte(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        wr = 1'b1;
        waddr = a;
        wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic fill_sector(input bit shuffle, input bit done_on_last);
        int order[DEPTH];
        for (int i = 0; i < DEPTH; i++) order[i] = i;
        if (shuffle) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                int j;
                int t;
                j = int'($urandom_range(0, i));
                t = order[i];
                order[i] = order[j];
                order[j] = t;
            end
        end
        if (done_on_last) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (order[i] == DEPTH - 1) begin
                    order[i] = order[DEPTH - 1];
                    order[DEPTH - 1] = DEPTH - 1;
                end
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            wr = 1'b1;
            waddr = 32'(order[k]);
            wdata = ref_mem[order[k]];
            done = done_on_last && (k == DEPTH - 1);
        end
        @(negedge clk);
        wr = 1'b0;
        done = 1'b0;
    endtask

    task automatic collect(input bit rand_ready);
        int         cyc = 0;
        int         extra = 0;
        bit         held = 1'b0;
        logic [7:0] pd = 8'h00;
        logic [AW-1:0] pi = '0;
        got_data.delete();
        got_idx.delete();
        unstable = 0;
        drain_cnt = 0;
        timed_out = 1'b0;
        while (extra < 4) begin
            @(negedge clk);
            cyc++;
            if (cyc > 20000) begin
                timed_out = 1'b1;
                break;
            end
            if (drained) drain_cnt++;
            if (held && (!rd_valid || rd_data !== pd || rd_index !== pi)) unstable++;
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_valid && ready) begin
                got_data.push_back(int'(rd_data));
                got_idx.push_back(int'(rd_index));
            end
            held = rd_valid && !ready;
            pd = rd_data;
            pi = rd_index;
            if (got_data.size() >= DEPTH) extra++;
        end
        ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (start_read !== 1'b0 || rd_valid !== 1'b0 || drained !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses got start=%b valid=%b drained=%b want 0 0 0",
                     start_read, rd_valid, drained);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow got %b want 0", overflow);
        end
        checks++;
        if (rd_data !== 8'h00 || rd_index !== '0 || checksum !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got data=%02h idx=%0d csum=%02h want 0 0 0",
                     rd_data, rd_index, checksum);
        end
    endtask

    task automatic test_ignored();
        do_reset();
        pulse_done();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL done_in_empty busy got %b want 0", busy);
        end
        write_byte(32'd3, 8'h11);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL write_in_empty overflow got %b want 1", overflow);
        end
    endtask

    task automatic test_basic_overflow();
        bit s1, b1, s2;
        int sc;
        do_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i);
        sc = start_cnt;
        do_fetch(s1, b1, s2);
        checks++;
        if (s1 !== 1'b1 || b1 !== 1'b1 || s2 !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse got start=%b busy=%b next=%b want 1 1 0", s1, b1, s2);
        end
        fill_sector(1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL no_early_overflow got %b want 0", overflow);
        end
        write_byte(32'd512, 8'hAA);
        write_byte(32'h0001_0000, 8'hAA);
        pulse_done();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow got %b want 1", overflow);
        end
        checks++;
        if (checksum !== exp_checksum()) begin
            errors++;
            $display("FAIL basic_checksum got %02h want %02h", checksum, exp_checksum());
        end
        collect(1'b0);
        checks++;
        if (timed_out || got_data.size() != DEPTH) begin
            errors++;
            $display("FAIL basic_count got %0d bytes timeout=%b want %0d", got_data.size(), timed_out, DEPTH);
        end
        for (int i = 0; i < got_data.size() && i < DEPTH; i++) begin
            checks++;
            if (got_idx[i] != i || got_data[i] != int'(ref_mem[i])) begin
                errors++;
                $display("FAIL basic_byte[%0d] got idx %0d data %02h want idx %0d data %02h",
                         i, got_idx[i], got_data[i], i, ref_mem[i]);
            end
        end
        checks++;
        if (drain_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_drained got pulses %0d busy %b want 1 0", drain_cnt, busy);
        end
        checks++;
        if (start_cnt - sc != 1) begin
            errors++;
            $display("FAIL basic_start_count got %0d want 1", start_cnt - sc);
        end
    endtask

    task automatic test_random_ready();
        bit s1, b1, s2;
        int sc;
        do_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'($urandom);
        sc = start_cnt;
        do_fetch(s1, b1, s2);
        fetch = 1'b1;
        fill_sector(1'b1, 1'b0);
        fetch = 1'b0;
        pulse_done();
        collect(1'b1);
        checks++;
        if (timed_out || got_data.size() != DEPTH) begin
            errors++;
            $display("FAIL rand_count got %0d bytes timeout=%b want %0d", got_data.size(), timed_out, DEPTH);
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL rand_stable got %0d changes while stalled want 0", unstable);
        end
        for (int i = 0; i < got_data.size() && i < DEPTH; i++) begin
            checks++;
            if (got_idx[i] != i || got_data[i] != int'(ref_mem[i])) begin
                errors++;
                $display("FAIL rand_byte[%0d] got idx %0d data %02h want idx %0d data %02h",
                         i, got_idx[i], got_data[i], i, ref_mem[i]);
            end
        end
        checks++;
        if (drain_cnt != 1 || start_cnt - sc != 1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rand_tail got drained %0d starts %0d ovf %b want 1 1 0",
                     drain_cnt, start_cnt - sc, overflow);
        end
    endtask

    task automatic test_write_with_done();
        bit s1, b1, s2;
        do_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'($urandom);
        ref_mem[DEPTH - 1] = 8'h5C;
        do_fetch(s1, b1, s2);
        fill_sector(1'b1, 1'b1);
        collect(1'b1);
        checks++;
        if (timed_out || got_data.size() != DEPTH) begin
            errors++;
            $display("FAIL wd_count got %0d bytes timeout=%b want %0d", got_data.size(), timed_out, DEPTH);
        end else begin
            checks++;
            if (got_data[DEPTH - 1] != 8'h5C || got_idx[DEPTH - 1] != DEPTH - 1) begin
                errors++;
                $display("FAIL wd_last got idx %0d data %02h want 511 5c",
                         got_idx[DEPTH - 1], got_data[DEPTH - 1]);
            end
            for (int i = 0; i < DEPTH - 1; i++) begin
                checks++;
                if (got_data[i] != int'(ref_mem[i])) begin
                    errors++;
                    $display("FAIL wd_byte[%0d] got %02h want %02h", i, got_data[i], ref_mem[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        bit s1, b1, s2;
        int dcount = 0;
        do_reset();
        do_fetch(s1, b1, s2);
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            wr = 1'b1;
            waddr = 32'(i);
            wdata = 8'($urandom);
        end
        @(negedge clk);
        wr = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || start_read !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got busy=%b valid=%b start=%b want 0 0 0", busy, rd_valid, start_read);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (drained) dcount++;
        end
        checks++;
        if (dcount != 0) begin
            errors++;
            $display("FAIL midrst_drained got %0d pulses want 0", dcount);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'($urandom);
        do_fetch(s1, b1, s2);
        checks++;
        if (s1 !== 1'b1 || b1 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_refetch got start=%b busy=%b want 1 1", s1, b1);
        end
        fill_sector(1'b0, 1'b0);
        pulse_done();
        collect(1'b1);
        checks++;
        if (timed_out || got_data.size() != DEPTH || drain_cnt != 1) begin
            errors++;
            $display("FAIL midrst_count got %0d bytes drained %0d want %0d 1", got_data.size(), drain_cnt, DEPTH);
        end
        for (int i = 0; i < got_data.size() && i < DEPTH; i++) begin
            checks++;
            if (got_idx[i] != i || got_data[i] != int'(ref_mem[i])) begin
                errors++;
                $display("FAIL midrst_byte[%0d] got idx %0d data %02h want %02h",
                         i, got_idx[i], got_data[i], ref_mem[i]);
            end
        end
    endtask

    task automatic test_checksum();
        bit s1, b1, s2;
        for (int p = 0; p < 3; p++) begin
            do_reset();
            for (int i = 0; i < DEPTH; i++) begin
                if (p == 0) ref_mem[i] = 8'h01;
                else if (p == 1) ref_mem[i] = 8'(i);
                else ref_mem[i] = (i == 0) ? 8'h7F : 8'h00;
            end
            do_fetch(s1, b1, s2);
            fill_sector(1'b1, 1'b0);
            pulse_done();
            checks++;
            if (checksum !== exp_checksum()) begin
                errors++;
                $display("FAIL checksum_p%0d got %02h want %02h", p, checksum, exp_checksum());
            end
            collect(1'b0);
            checks++;
            if (checksum !== exp_checksum() || drain_cnt != 1) begin
                errors++;
                $display("FAIL checksum_hold_p%0d got %02h drained %0d want %02h 1",
                         p, checksum, drain_cnt, exp_checksum());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ignored();
        test_basic_overflow();
        test_random_ready();
        test_write_with_done();
        test_reset_mid_fill();
        test_checksum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
